// File: rtl/wf_dm_pkg.sv
// rtl/wf_dm_pkg.sv - shared types, field positions and helpers for the waveform datamover sequencer
package wf_dm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_CMD = 3'd1,
    LOAD_STS = 3'd2,
    PLAY_CMD = 3'd3,
    PLAY_STS = 3'd4
  } state_t;

  localparam int CMD_W        = 72;
  localparam int TAG_W        = 4;
  localparam int CMD_TAG_LSB  = 64;
  localparam int CMD_ADDR_LSB = 32;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_INCR_BIT = 23;
  localparam int CMD_LEN_W    = 23;
  localparam int CMD_ADDR_W   = 32;

  localparam int STS_OKAY_BIT = 7;
  localparam int STS_ERR_MSB  = 6;
  localparam int STS_ERR_LSB  = 4;
  localparam int STS_TAG_MSB  = 3;

  localparam logic [7:0] ERR_ZERO_LEN = 8'hFF;

  function automatic logic [CMD_W-1:0] build_cmd(input logic [TAG_W-1:0] tag,
                                                 input logic [CMD_ADDR_W-1:0] addr,
                                                 input logic [CMD_LEN_W-1:0] len);
    logic [CMD_W-1:0] c;
    c = '0;
    c[CMD_TAG_LSB +: TAG_W]       = tag;
    c[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
    c[CMD_EOF_BIT]                = 1'b1;
    c[CMD_INCR_BIT]               = 1'b1;
    c[CMD_LEN_W-1:0]              = len;
    return c;
  endfunction

  // A status is good only if OKAY is set, no error bits, and the tag matches the issued command.
  function automatic logic sts_good(input logic [7:0] sts, input logic [TAG_W-1:0] tag);
    return sts[STS_OKAY_BIT] &&
           (sts[STS_ERR_MSB:STS_ERR_LSB] == 3'b000) &&
           (sts[STS_TAG_MSB:0] == tag);
  endfunction

endpackage

// File: rtl/waveform_dm_ctrl.sv
// rtl/waveform_dm_ctrl.sv - arbitrates waveform load/play requests into datamover commands
module waveform_dm_ctrl
  import wf_dm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BTT_W  = 23,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in1,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wf_base_addr,
  input  logic [BTT_W-1:0]  wf_len_bytes,
  input  logic [CNT_W-1:0]  play_count,
  input  logic              load_req,
  input  logic              play_req,
  input  logic              stop,
  output logic [71:0]       s2mm_cmd_tdata,
  output logic              s2mm_cmd_tvalid,
  input  logic              s2mm_cmd_tready,
  output logic [71:0]       mm2s_cmd_tdata,
  output logic              mm2s_cmd_tvalid,
  input  logic              mm2s_cmd_tready,
  input  logic [7:0]        s2mm_sts_tdata,
  input  logic              s2mm_sts_tvalid,
  output logic              s2mm_sts_tready,
  input  logic [7:0]        mm2s_sts_tdata,
  input  logic              mm2s_sts_tvalid,
  output logic              mm2s_sts_tready,
  output logic              busy,
  output logic              load_done,
  output logic              play_done,
  output logic              err,
  output logic [7:0]        err_code
);

  state_t             state_q, state_d;
  logic               load_pend, play_pend;
  logic [TAG_W-1:0]   tag_q, issued_tag;
  logic [ADDR_W-1:0]  addr_q;
  logic [BTT_W-1:0]   len_q;
  logic [CNT_W-1:0]   iter_cnt;
  logic               stop_seen;

  logic accept_load, accept_play, zero_len;
  logic load_ok, play_fin, play_next, sts_bad;
  logic load_active, play_active, cmd_hs;
  logic [CMD_W-1:0] cmd_word;

  assign load_active = (state_q == LOAD_CMD) || (state_q == LOAD_STS);
  assign play_active = (state_q == PLAY_CMD) || (state_q == PLAY_STS);
  assign zero_len    = (wf_len_bytes == '0);
  assign cmd_hs      = (s2mm_cmd_tvalid && s2mm_cmd_tready) ||
                       (mm2s_cmd_tvalid && mm2s_cmd_tready);
  assign busy        = (state_q != IDLE);

  assign cmd_word        = build_cmd(tag_q, CMD_ADDR_W'(addr_q), CMD_LEN_W'(len_q));
  assign s2mm_cmd_tdata  = s2mm_cmd_tvalid ? cmd_word : '0;
  assign mm2s_cmd_tdata  = mm2s_cmd_tvalid ? cmd_word : '0;

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    s2mm_cmd_tvalid = 1'b0;
    mm2s_cmd_tvalid = 1'b0;
    s2mm_sts_tready = 1'b0;
    mm2s_sts_tready = 1'b0;
    accept_load     = 1'b0;
    accept_play     = 1'b0;
    load_ok         = 1'b0;
    play_fin        = 1'b0;
    play_next       = 1'b0;
    sts_bad         = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_pend) begin
          accept_load = 1'b1;
          if (!zero_len) state_d = LOAD_CMD;
        end else if (play_pend) begin
          accept_play = 1'b1;
          if (!zero_len) state_d = PLAY_CMD;
        end
      end
      LOAD_CMD: begin
        s2mm_cmd_tvalid = 1'b1;
        if (s2mm_cmd_tready) state_d = LOAD_STS;
      end
      LOAD_STS: begin
        s2mm_sts_tready = 1'b1;
        if (s2mm_sts_tvalid) begin
          state_d = IDLE;
          if (sts_good(s2mm_sts_tdata, issued_tag)) load_ok = 1'b1;
          else                                      sts_bad = 1'b1;
        end
      end
      PLAY_CMD: begin
        mm2s_cmd_tvalid = 1'b1;
        if (mm2s_cmd_tready) state_d = PLAY_STS;
      end
      PLAY_STS: begin
        mm2s_sts_tready = 1'b1;
        if (mm2s_sts_tvalid) begin
          if (!sts_good(mm2s_sts_tdata, issued_tag)) begin
            sts_bad = 1'b1;
            state_d = IDLE;
          end else if (stop_seen || stop || (iter_cnt == CNT_W'(1)) || load_pend) begin
            // a waiting load takes over only here, between play iterations
            play_fin = 1'b1;
            state_d  = IDLE;
          end else begin
            play_next = 1'b1;
            state_d   = PLAY_CMD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      load_pend  <= 1'b0;
      play_pend  <= 1'b0;
      tag_q      <= '0;
      issued_tag <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      iter_cnt   <= '0;
      stop_seen  <= 1'b0;
      load_done  <= 1'b0;
      play_done  <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      load_done <= load_ok;
      play_done <= play_fin;

      if (accept_load)                load_pend <= 1'b0;
      if (load_req && !load_active)   load_pend <= 1'b1;
      if (accept_play)                play_pend <= 1'b0;
      if (play_req && !play_active)   play_pend <= 1'b1;

      if (state_q == IDLE)            stop_seen <= 1'b0;
      else if (stop && play_active)   stop_seen <= 1'b1;

      if (cmd_hs) begin
        issued_tag <= tag_q;
        tag_q      <= tag_q + TAG_W'(1);
      end

      if (accept_load || accept_play) begin
        addr_q   <= wf_base_addr;
        len_q    <= wf_len_bytes;
        err      <= zero_len;
        err_code <= zero_len ? ERR_ZERO_LEN : 8'h00;
      end

      // play_count of zero means run until stop, so the counter is left parked at zero
      if (accept_play)                          iter_cnt <= play_count;
      else if (play_next && iter_cnt != '0)     iter_cnt <= iter_cnt - CNT_W'(1);

      if (sts_bad) begin
        err      <= 1'b1;
        err_code <= (state_q == LOAD_STS) ? s2mm_sts_tdata : mm2s_sts_tdata;
      end
    end
  end

endmodule

// File: tb/tb_waveform_dm_ctrl.sv
// tb/tb_waveform_dm_ctrl.sv - self-checking bench for waveform_dm_ctrl
module tb_waveform_dm_ctrl;

  logic        clk_in1 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wf_base_addr = '0;
  logic [22:0] wf_len_bytes = '0;
  logic [15:0] play_count = '0;
  logic        load_req = 1'b0, play_req = 1'b0, stop = 1'b0;
  logic [71:0] s2mm_cmd_tdata, mm2s_cmd_tdata;
  logic        s2mm_cmd_tvalid, mm2s_cmd_tvalid;
  logic        s2mm_cmd_tready = 1'b1, mm2s_cmd_tready = 1'b1;
  logic [7:0]  s2mm_sts_tdata = '0, mm2s_sts_tdata = '0;
  logic        s2mm_sts_tvalid = 1'b0, mm2s_sts_tvalid = 1'b0;
  logic        s2mm_sts_tready, mm2s_sts_tready;
  logic        busy, load_done, play_done, err;
  logic [7:0]  err_code;

  waveform_dm_ctrl dut (
    .clk_in1(clk_in1), .reset(reset),
    .wf_base_addr(wf_base_addr), .wf_len_bytes(wf_len_bytes), .play_count(play_count),
    .load_req(load_req), .play_req(play_req), .stop(stop),
    .s2mm_cmd_tdata(s2mm_cmd_tdata), .s2mm_cmd_tvalid(s2mm_cmd_tvalid), .s2mm_cmd_tready(s2mm_cmd_tready),
    .mm2s_cmd_tdata(mm2s_cmd_tdata), .mm2s_cmd_tvalid(mm2s_cmd_tvalid), .mm2s_cmd_tready(mm2s_cmd_tready),
    .s2mm_sts_tdata(s2mm_sts_tdata), .s2mm_sts_tvalid(s2mm_sts_tvalid), .s2mm_sts_tready(s2mm_sts_tready),
    .mm2s_sts_tdata(mm2s_sts_tdata), .mm2s_sts_tvalid(mm2s_sts_tvalid), .mm2s_sts_tready(mm2s_sts_tready),
    .busy(busy), .load_done(load_done), .play_done(play_done), .err(err), .err_code(err_code)
  );

  always #5 clk_in1 = ~clk_in1;

  int n_chk = 0;
  int n_pass = 0;

  // reference state: next tag to be used and the tag of the last issued command
  logic [3:0]  mtag = '0;
  logic [3:0]  last_tag = '0;
  logic [31:0] exp_addr = '0;
  logic [22:0] exp_len = '0;

  typedef struct {
    logic [31:0] addr;
    logic [22:0] len;
    logic [7:0]  sts;
    logic        done;
    logic        e;
    logic [7:0]  code;
  } load_vec_t;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk_in1);
  endtask

  function automatic logic [71:0] exp_cmd(input logic [3:0] t, input logic [31:0] a, input logic [22:0] l);
    return {4'h0, t, a, 1'b0, 1'b1, 6'h00, 1'b1, l};
  endfunction

  task automatic pulse(input bit ld, input bit pl);
    load_req = ld;
    play_req = pl;
    tick();
    load_req = 1'b0;
    play_req = 1'b0;
  endtask

  task automatic wait_cmd(input bit ch, input string nm, output int lat);
    logic v;
    lat = 0;
    v = ch ? mm2s_cmd_tvalid : s2mm_cmd_tvalid;
    while (!v && lat < 20) begin
      tick();
      lat++;
      v = ch ? mm2s_cmd_tvalid : s2mm_cmd_tvalid;
    end
    chk({nm, " cmd_valid"}, v, 1);
    chk({nm, " other_cmd_valid"}, ch ? s2mm_cmd_tvalid : mm2s_cmd_tvalid, 0);
    if (v) begin
      chk({nm, " cmd_data"}, ch ? mm2s_cmd_tdata : s2mm_cmd_tdata, exp_cmd(mtag, exp_addr, exp_len));
      last_tag = mtag;
      mtag = mtag + 4'd1;
      tick();
    end
  endtask

  task automatic send_sts(input bit ch, input logic [7:0] s, input string nm);
    int n = 0;
    while (!(ch ? mm2s_sts_tready : s2mm_sts_tready) && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " sts_ready"}, ch ? mm2s_sts_tready : s2mm_sts_tready, 1);
    chk({nm, " other_sts_ready"}, ch ? s2mm_sts_tready : mm2s_sts_tready, 0);
    if (ch) begin mm2s_sts_tdata = s; mm2s_sts_tvalid = 1'b1; end
    else    begin s2mm_sts_tdata = s; s2mm_sts_tvalid = 1'b1; end
    tick();
    mm2s_sts_tvalid = 1'b0;
    s2mm_sts_tvalid = 1'b0;
  endtask

  task automatic quiet(input int cycles, input string nm);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen = seen | s2mm_cmd_tvalid | mm2s_cmd_tvalid;
      tick();
    end
    chk({nm, " no_cmd"}, seen, 0);
  endtask

  function automatic logic [7:0] mk_sts(input int mode);
    case (mode)
      0:       return {4'h8, last_tag ^ 4'($urandom_range(1, 15))};
      1:       return {1'b1, 3'($urandom_range(1, 7)), last_tag};
      2:       return {4'h0, last_tag};
      default: return {4'h8, last_tag};
    endcase
  endfunction

  task automatic set_req(input logic [31:0] a, input logic [22:0] l, input logic [15:0] c);
    wf_base_addr = a;
    wf_len_bytes = l;
    play_count = c;
    exp_addr = a;
    exp_len = l;
  endtask

  task automatic run_zero(input bit ld, input string nm);
    set_req($urandom, 23'd0, 16'd2);
    pulse(ld, !ld);
    tick();
    chk({nm, " err"}, err, 1);
    chk({nm, " err_code"}, err_code, 8'hFF);
    chk({nm, " busy"}, busy, 0);
    quiet(3, nm);
  endtask

  task automatic run_load(input logic [31:0] a, input logic [22:0] l, input int mode, input string nm);
    int lat;
    logic [7:0] s;
    set_req(a, l, 16'd0);
    pulse(1, 0);
    wait_cmd(0, nm, lat);
    s = mk_sts(mode);
    send_sts(0, s, nm);
    chk({nm, " load_done"}, load_done, (mode < 0 || mode > 2) ? 1 : 0);
    chk({nm, " err"}, err, (mode < 0 || mode > 2) ? 0 : 1);
    if (mode >= 0 && mode <= 2) chk({nm, " err_code"}, err_code, s);
    tick();
    chk({nm, " idle"}, {busy, load_done}, 2'b00);
  endtask

  task automatic run_play(input logic [31:0] a, input logic [22:0] l, input int cnt, input int bad_iter,
                          input string nm);
    int lat;
    logic [7:0] s;
    set_req(a, l, 16'(cnt));
    pulse(0, 1);
    for (int i = 1; i <= cnt; i++) begin
      wait_cmd(1, nm, lat);
      s = (i == bad_iter) ? mk_sts($urandom_range(0, 2)) : mk_sts(-1);
      send_sts(1, s, nm);
      if (i == bad_iter) begin
        chk({nm, " bad err"}, {err, err_code}, {1'b1, s});
        chk({nm, " bad no_done"}, play_done, 0);
        break;
      end else if (i == cnt) begin
        chk({nm, " play_done"}, {play_done, err}, 2'b10);
      end else begin
        chk({nm, " mid_iter"}, {play_done, busy}, 2'b01);
      end
    end
    tick();
    chk({nm, " end_busy"}, busy, 0);
    quiet(3, nm);
  endtask

  load_vec_t lv[8];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [71:0] held;
    lv[0] = '{32'h0000_0100, 23'd4096,    8'h80, 1'b1, 1'b0, 8'h00};
    lv[1] = '{32'hDEAD_BEE0, 23'h7F_FFFF, 8'h81, 1'b1, 1'b0, 8'h00};
    lv[2] = '{32'h0000_2000, 23'd0,       8'h00, 1'b0, 1'b1, 8'hFF};
    lv[3] = '{32'h0000_3000, 23'd1,       8'h82, 1'b1, 1'b0, 8'h00};
    lv[4] = '{32'h0000_4000, 23'd16,      8'h80, 1'b0, 1'b1, 8'h80};
    lv[5] = '{32'h0000_5000, 23'd8,       8'hA4, 1'b0, 1'b1, 8'hA4};
    lv[6] = '{32'h0000_6000, 23'd32,      8'h05, 1'b0, 1'b1, 8'h05};
    lv[7] = '{32'h0000_7000, 23'd64,      8'h86, 1'b1, 1'b0, 8'h00};

    tick();
    chk("reset ctl", {s2mm_cmd_tvalid, mm2s_cmd_tvalid, s2mm_sts_tready, mm2s_sts_tready,
                      busy, load_done, play_done, err, err_code}, 0);
    chk("reset data", {s2mm_cmd_tdata, mm2s_cmd_tdata}, 0);
    reset = 1'b0;
    tick();

    // table of single loads from reset: tag sequence 0,1,(zero-len skips),2,3,...
    foreach (lv[k]) begin
      set_req(lv[k].addr, lv[k].len, 16'd0);
      pulse(1, 0);
      chk($sformatf("vec%0d lat_early", k), s2mm_cmd_tvalid, 0);
      tick();
      if (lv[k].len == 0) begin
        chk($sformatf("vec%0d zero", k), {s2mm_cmd_tvalid, busy, err, err_code}, {3'b001, lv[k].code});
        quiet(3, $sformatf("vec%0d", k));
      end else begin
        wait_cmd(0, $sformatf("vec%0d", k), lat);
        chk($sformatf("vec%0d latency", k), lat, 0);
        send_sts(0, lv[k].sts, $sformatf("vec%0d", k));
        chk($sformatf("vec%0d result", k), {load_done, err, err_code}, {lv[k].done, lv[k].e, lv[k].code});
        tick();
        chk($sformatf("vec%0d after", k), {load_done, busy}, 2'b00);
      end
    end

    // stalled command holds its data, then reset aborts asynchronously
    s2mm_cmd_tready = 1'b0;
    set_req(32'h0000_9000, 23'd128, 16'd0);
    pulse(1, 0);
    tick();
    held = s2mm_cmd_tdata;
    chk("stall valid", s2mm_cmd_tvalid, 1);
    chk("stall data", held, exp_cmd(mtag, exp_addr, exp_len));
    repeat (3) tick();
    chk("stall stable", {s2mm_cmd_tvalid, s2mm_cmd_tdata}, {1'b1, held});
    #2 reset = 1'b1;
    #1;
    chk("async reset ctl", {s2mm_cmd_tvalid, mm2s_cmd_tvalid, s2mm_sts_tready, mm2s_sts_tready,
                            busy, load_done, play_done, err, err_code}, 0);
    chk("async reset data", s2mm_cmd_tdata, 0);
    tick();
    reset = 1'b0;
    s2mm_cmd_tready = 1'b1;
    mtag = 4'd0;
    tick();

    run_load(32'h0000_0100, 23'd4096, -1, "load0");

    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_play(32'h0001_0000, 23'd2048, 3, 0, "play3");

    // simultaneous requests: load first, then play
    set_req(32'h0002_0000, 23'd512, 16'd1);
    pulse(1, 1);
    wait_cmd(0, "simul load", lat);
    send_sts(0, mk_sts(-1), "simul load");
    chk("simul load_done", load_done, 1);
    wait_cmd(1, "simul play", lat);
    send_sts(1, mk_sts(-1), "simul play");
    chk("simul play_done", play_done, 1);
    tick();

    // continuous play stopped during the second status wait
    set_req(32'h0003_0000, 23'd256, 16'd0);
    pulse(0, 1);
    wait_cmd(1, "cont it1", lat);
    send_sts(1, mk_sts(-1), "cont it1");
    chk("cont it1 no_done", play_done, 0);
    wait_cmd(1, "cont it2", lat);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    send_sts(1, mk_sts(-1), "cont it2");
    chk("cont play_done", play_done, 1);
    tick();
    quiet(5, "cont stop");

    // SLVERR on first of five iterations, then a new play clears err
    set_req(32'h0004_0000, 23'd100, 16'd5);
    pulse(0, 1);
    wait_cmd(1, "slverr", lat);
    send_sts(1, 8'h40, "slverr");
    chk("slverr err", {err, err_code, play_done}, {1'b1, 8'h40, 1'b0});
    tick();
    chk("slverr idle", busy, 0);
    quiet(5, "slverr");
    set_req(32'h0004_1000, 23'd100, 16'd1);
    pulse(0, 1);
    wait_cmd(1, "reclear", lat);
    chk("reclear err", {err, err_code}, 0);
    send_sts(1, mk_sts(-1), "reclear");
    chk("reclear done", play_done, 1);
    tick();

    // pending load preempts a four-iteration play after its first iteration
    set_req(32'h0005_0000, 23'd300, 16'd4);
    pulse(0, 1);
    wait_cmd(1, "preempt play", lat);
    set_req(32'h0006_0000, 23'd77, 16'd4);
    pulse(1, 0);
    send_sts(1, mk_sts(-1), "preempt play");
    chk("preempt play_done", play_done, 1);
    wait_cmd(0, "preempt load", lat);
    send_sts(0, mk_sts(-1), "preempt load");
    chk("preempt load_done", load_done, 1);
    tick();
    quiet(3, "preempt");

    // randomized operations against the reference model
    for (int r = 0; r < 40; r++) begin
      int op;
      logic [22:0] l;
      op = $urandom_range(0, 1);
      l = 23'($urandom_range(1, 8388607));
      if ($urandom_range(0, 7) == 0) begin
        run_zero(op == 0, $sformatf("rnd%0d zero", r));
      end else if (op == 0) begin
        run_load($urandom, l, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1,
                 $sformatf("rnd%0d load", r));
      end else begin
        int c;
        c = $urandom_range(1, 4);
        run_play($urandom, l, c, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, c)) : 0,
                 $sformatf("rnd%0d play", r));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/waveform_dm_ctrl.md
Name: waveform_dm_ctrl

Overview:
- Command/status sequencer for the waveform datamover/BRAM pair.
- Accepts two requesters: waveform LOAD (S2MM, stream to BRAM) and PLAY (MM2S, BRAM to stream, repeated N times).
- Arbitrates between them, builds 72-bit datamover commands and consumes 8-bit status words.
- Reports done/error back to the radar control logic.

Parameters:
- ADDR_W, 32, datamover address width (cmd bits [63:32]).
- BTT_W, 23, bytes-to-transfer width (cmd bits [22:0]).
- CNT_W, 16, width of play repeat counter.

Ports:
- clk_in1  in  1  system clock; all logic on this edge.
- reset  in  1  asynchronous, active-high reset.
- wf_base_addr  in  ADDR_W  BRAM byte address of waveform; sampled on request accept.
- wf_len_bytes  in  BTT_W  transfer length in bytes; sampled on request accept.
- play_count  in  CNT_W  number of MM2S repeats; 0 = continuous until stop.
- load_req  in  1  single-cycle load request pulse.
- play_req  in  1  single-cycle play request pulse.
- stop  in  1  stop continuous/repeated play after current transfer.
- s2mm_cmd_tdata  out  72  S2MM command.
- s2mm_cmd_tvalid  out  1  S2MM command valid.
- s2mm_cmd_tready  in  1  S2MM command ready.
- mm2s_cmd_tdata  out  72  MM2S command.
- mm2s_cmd_tvalid  out  1  MM2S command valid.
- mm2s_cmd_tready  in  1  MM2S command ready.
- s2mm_sts_tdata  in  8  S2MM status.
- s2mm_sts_tvalid  in  1  S2MM status valid.
- s2mm_sts_tready  out  1  S2MM status ready.
- mm2s_sts_tdata  in  8  MM2S status.
- mm2s_sts_tvalid  in  1  MM2S status valid.
- mm2s_sts_tready  out  1  MM2S status ready.
- busy  out  1  high whenever state != IDLE.
- load_done  out  1  one-cycle pulse on good S2MM status.
- play_done  out  1  one-cycle pulse when final play iteration completes or stop takes effect.
- err  out  1  sticky error flag.
- err_code  out  8  captured status byte; 8'hFF = zero-length request rejected.

Behaviour:
- Reset: all outputs 0; state IDLE; pending flags and tag counter cleared.
- Pending flags: load_req/play_req set load_pend/play_pend in any state. A pulse during an active op of the same type is dropped.
- Command format: [71:68]=0, [67:64]=tag, [63:32]=addr, [31]=0, [30]=1 (EOF), [29:24]=0, [23]=1 (INCR), [22:0]=len.
- Tag counter: 4-bit, increments after every command handshake, wraps 15->0.
- IDLE:
  - load_pend has priority over play_pend when both are set.
  - On accept: latch addr/len; clear err/err_code; clear that pending flag.
  - Zero len: no command; err=1, err_code=FF, stay IDLE.
  - Play accept also loads iter_cnt=play_count.
- LOAD_CMD: s2mm_cmd_tvalid=1, tdata stable until tready. Handshake -> LOAD_STS.
- LOAD_STS: s2mm_sts_tready=1. On tvalid:
  - good = bit7 (OKAY) set, bits[6:4]=0, bits[3:0]==issued tag.
  - good -> load_done pulse, IDLE.
  - bad -> err=1, err_code=status, IDLE.
- PLAY_CMD: mm2s_cmd_tvalid=1 until tready -> PLAY_STS.
- PLAY_STS: mm2s_sts_tready=1. On good status:
  - If stop_seen, or iter_cnt==1, or load_pend: play_done pulse, IDLE. Load preempts play only between iterations.
  - Otherwise decrement iter_cnt (no decrement when play_count==0) and return to PLAY_CMD on the next cycle.
  - Bad status -> err, IDLE, remaining iterations discarded.
- stop_seen: set by stop while in a PLAY_* state; cleared in IDLE. stop in IDLE is ignored.
- Latency: request pulse -> cmd_tvalid = 2 cycles (pending register, then state).
- Only one command is outstanding at a time; status for the other channel is never accepted (its tready=0).
- Reset mid-transfer aborts immediately. The datamover must be reset in the same domain.

Decomposition:
- Package wf_dm_pkg: state enum (IDLE, LOAD_CMD, LOAD_STS, PLAY_CMD, PLAY_STS), command field bit positions, status bit positions, ERR_ZERO_LEN=8'hFF, function build_cmd(tag, addr, len).
- No sub-module; a single FSM file is natural.

Test Plan:
- Load: load_req, addr=0x100, len=4096, tready=1 -> s2mm cmd = {4'h0, tag0, 32'h100, 1'b0, 1'b1, 6'h0, 1'b1, 23'd4096}; sts 8'h80 -> load_done 1 cycle, busy falls.
- Play x3: play_count=3, good statuses with tags 1,2,3 -> exactly 3 mm2s commands, one play_done after the third.
- Simultaneous load_req+play_req -> S2MM command first; after its status, MM2S command issued.
- Continuous play (count=0), stop asserted during second PLAY_STS -> play_done after that status, no third command.
- Bad status 8'h40 (SLVERR) on play iteration 1 of 5 -> err=1, err_code=40, IDLE, no further commands; next play_req clears err.
- len=0 request -> no cmd_tvalid, err_code=FF. Separately, reset asserted while in LOAD_CMD -> tvalid drops asynchronously, all outputs 0.
